// File: rtl/led_bank_arbiter_if.sv
// LED bank arbiter bus: requester side (master) and arbiter side (slave).
interface led_bank_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]    req;
  logic [16*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    gnt;
  logic [15:0]           signals;
  logic                  led;
  logic                  busy;

  modport master (
    output req, src_data,
    input  gnt, signals, led, busy
  );

  modport slave (
    input  req, src_data,
    output gnt, signals, led, busy
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin sharing of the 16-bit LED bank and status LED
// between up to four requesters, with a minimum dwell time in prescaled ticks
// and a free-running heartbeat shown while nobody owns the bank.
// Optional macro LED_HANDOFF_BLANK_EN: every ownership change from an owner
// passes through a blanked state held until the next tick.
module led_bank_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int PRESCALE_W  = 4,
  parameter int DWELL_TICKS = 8,
  parameter int HB_W        = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  led_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef LED_HANDOFF_BLANK_EN
    ST_BLANK = 2'd2,
`endif
    ST_OWN   = 2'd1
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [HB_W-1:0]       hb_q, hb_d;
  logic [7:0]            dwell_q, dwell_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [NUM_SRC-1:0]    gnt_q, gnt_d;
  logic [15:0]           signals_q, signals_d;
  logic                  led_q, led_d;
  logic                  busy_q, busy_d;

  logic                  tick;
  logic [NUM_SRC-1:0]    cand;
  logic                  win_found;
  logic [1:0]            win_idx;
  logic [NUM_SRC-1:0]    win_onehot;
  logic [1:0]            win_next_ptr;
  logic                  owner_req;
  logic [15:0]           owner_data;

  assign tick = &prescaler_q;

  // The current owner is masked out, so one search serves initial grant,
  // release handoff and dwell-expiry rotation alike (ptr is always owner+1).
  assign cand = bus.req & ~gnt_q;

  // Round-robin winner search starting at ptr.
  always_comb begin
    int unsigned j;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    j          = 0;
    for (int unsigned i = 0; i < unsigned'(NUM_SRC); i++) begin
      j = 32'(ptr_q) + i;
      if (j >= unsigned'(NUM_SRC)) j = j - unsigned'(NUM_SRC);
      if (!win_found && cand[j]) begin
        win_found     = 1'b1;
        win_idx       = j[1:0];
        win_onehot    = '0;
        win_onehot[j] = 1'b1;
      end
    end
    win_next_ptr = (32'(win_idx) + 1 == unsigned'(NUM_SRC)) ? 2'd0 : win_idx + 2'd1;
  end

  // Owner request and pattern selected by the one-hot grant.
  always_comb begin
    owner_req  = |(bus.req & gnt_q);
    owner_data = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_SRC); i++) begin
      if (gnt_q[i]) owner_data = owner_data | bus.src_data[16*i +: 16];
    end
  end

  // Next-state and registered-output logic for prescaler, heartbeat and FSM.
  always_comb begin
    prescaler_d = prescaler_q + PRESCALE_W'(1);
    hb_d        = tick ? hb_q + HB_W'(1) : hb_q;
    led_d       = hb_q[HB_W-1];
    state_d     = state_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    signals_d   = signals_q;
    dwell_d     = dwell_q;
    ptr_d       = ptr_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d     = '0;
        busy_d    = 1'b0;
        signals_d = hb_q[HB_W-9 -: 16];
        if (win_found) begin
          state_d = ST_OWN;
          gnt_d   = win_onehot;
          busy_d  = 1'b1;
          dwell_d = 8'(DWELL_TICKS);
          ptr_d   = win_next_ptr;
        end
      end

      ST_OWN: begin
        busy_d    = 1'b1;
        signals_d = owner_data;
        if (tick && dwell_q != 8'd0) dwell_d = dwell_q - 8'd1;
        if (!owner_req || (dwell_q == 8'd0 && win_found)) begin
`ifdef LED_HANDOFF_BLANK_EN
          state_d   = ST_BLANK;
          gnt_d     = '0;
          signals_d = '0;
`else
          if (win_found) begin
            gnt_d   = win_onehot;
            dwell_d = 8'(DWELL_TICKS);
            ptr_d   = win_next_ptr;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
`endif
        end
      end

`ifdef LED_HANDOFF_BLANK_EN
      ST_BLANK: begin
        gnt_d     = '0;
        busy_d    = 1'b1;
        signals_d = '0;
        if (tick) begin
          if (win_found) begin
            state_d = ST_OWN;
            gnt_d   = win_onehot;
            dwell_d = 8'(DWELL_TICKS);
            ptr_d   = win_next_ptr;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      prescaler_q <= '0;
      hb_q        <= '0;
      dwell_q     <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      signals_q   <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      hb_q        <= hb_d;
      dwell_q     <= dwell_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      signals_q   <= signals_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.signals = signals_q;
  assign bus.led     = led_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed self-checking bench for led_bank_arbiter (default parameters).
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc;

  led_bank_arbiter_if #(.NUM_SRC(4)) bus_if ();

  led_bank_arbiter #(
    .NUM_SRC    (4),
    .PRESCALE_W (4),
    .DWELL_TICKS(8),
    .HB_W       (31)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Posedges seen since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic do_reset();
    bus_if.req = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_sig;
    bus_if.req      = '0;
    bus_if.src_data = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0 || bus_if.signals !== 16'h0000 || bus_if.led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: gnt=%b busy=%b signals=%h led=%b, want 0", bus_if.gnt, bus_if.busy, bus_if.signals, bus_if.led);
    end
    reset_n = 1'b1;
    // Heartbeat bits [22:7] first change after edge 2049.
    repeat (2048) @(negedge clk);
    exp_sig = 16'((((cyc - 1) / 16) >> 7) & 32'hFFFF);
    tests_run++;
    if (bus_if.signals !== exp_sig || exp_sig !== 16'h0000) begin
      tests_failed++;
      $display("FAIL hb_before_step: signals=%h want %h (cyc %0d)", bus_if.signals, 16'h0000, cyc);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.signals !== 16'h0001) begin
      tests_failed++;
      $display("FAIL hb_step: signals=%h want 0001 (cyc %0d)", bus_if.signals, cyc);
    end
    repeat (40000) @(negedge clk);
    exp_sig = 16'((((cyc - 1) / 16) >> 7) & 32'hFFFF);
    tests_run++;
    if (bus_if.signals !== exp_sig) begin
      tests_failed++;
      $display("FAIL hb_idle: signals=%h want %h (cyc %0d)", bus_if.signals, exp_sig, cyc);
    end
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0 || bus_if.led !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_outputs: gnt=%b busy=%b led=%b want 0/0/0", bus_if.gnt, bus_if.busy, bus_if.led);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus_if.src_data = {16'h4444, 16'h3333, 16'hA5A5, 16'h1111};
    bus_if.req      = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0010 || bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%b busy=%b want 0010/1", bus_if.gnt, bus_if.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.signals !== 16'hA5A5) begin
      tests_failed++;
      $display("FAIL single_data: signals=%h want a5a5", bus_if.signals);
    end
    repeat (1100) @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0010 || bus_if.signals !== 16'hA5A5 || bus_if.led !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_hold: gnt=%b signals=%h led=%b want 0010/a5a5/0", bus_if.gnt, bus_if.signals, bus_if.led);
    end
    bus_if.src_data[31:16] = 16'h5A5A;
    @(negedge clk);
    tests_run++;
    if (bus_if.signals !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL data_latency: signals=%h want 5a5a", bus_if.signals);
    end
    bus_if.req = 4'b0000;
    @(negedge clk);
`ifdef LED_HANDOFF_BLANK_EN
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b1 || bus_if.signals !== 16'h0000) begin
      tests_failed++;
      $display("FAIL release_blank: gnt=%b busy=%b signals=%h want 0000/1/0000", bus_if.gnt, bus_if.busy, bus_if.signals);
    end
    for (int i = 0; i < 40 && bus_if.busy === 1'b1; i++) @(negedge clk);
`endif
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_idle: gnt=%b busy=%b want 0000/0", bus_if.gnt, bus_if.busy);
    end
  endtask

  task automatic test_rotation();
    logic [15:0] pat [4];
    int          order [4];
    logic [3:0]  prev;
    logic [3:0]  exp_gnt;
    int          count;
    pat[0] = 16'h0F0F; pat[1] = 16'h1234; pat[2] = 16'hC3C3; pat[3] = 16'h8001;
    order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 0;
    do_reset();
    bus_if.src_data = {pat[3], pat[2], pat[1], pat[0]};
    bus_if.req      = 4'b1111;
    @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rr_first: gnt=%b want 0001", bus_if.gnt);
    end
    count = 0;
    for (int k = 0; k < 4; k++) begin
      prev = bus_if.gnt;
      while ((bus_if.gnt === prev || bus_if.gnt === 4'b0000) && count < 300) begin
        @(negedge clk);
        count++;
      end
      exp_gnt = 4'b0001 << order[k];
      tests_run++;
      if (bus_if.gnt !== exp_gnt || count < 112 || count > 160) begin
        tests_failed++;
        $display("FAIL rr_step%0d: gnt=%b after %0d clk, want %b after 112..160 clk", k, bus_if.gnt, count, exp_gnt);
      end
      @(negedge clk);
      count = 1;
      tests_run++;
      if (bus_if.signals !== pat[order[k]]) begin
        tests_failed++;
        $display("FAIL rr_data%0d: signals=%h want %h", k, bus_if.signals, pat[order[k]]);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus_if.src_data = {16'h0000, 16'h2222, 16'h0000, 16'h7E7E};
    bus_if.req      = 4'b0100;
    @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL drop_grant2: gnt=%b want 0100", bus_if.gnt);
    end
    bus_if.req = 4'b0101;
    repeat (55) @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0100 || bus_if.signals !== 16'h2222) begin
      tests_failed++;
      $display("FAIL drop_held: gnt=%b signals=%h want 0100/2222", bus_if.gnt, bus_if.signals);
    end
    bus_if.req = 4'b0001;
    @(negedge clk);
`ifdef LED_HANDOFF_BLANK_EN
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b1 || bus_if.signals !== 16'h0000) begin
      tests_failed++;
      $display("FAIL drop_blank: gnt=%b busy=%b signals=%h want 0000/1/0000", bus_if.gnt, bus_if.busy, bus_if.signals);
    end
    for (int i = 0; i < 40 && bus_if.gnt === 4'b0000; i++) @(negedge clk);
`endif
    tests_run++;
    if (bus_if.gnt !== 4'b0001 || bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_handoff: gnt=%b busy=%b want 0001/1", bus_if.gnt, bus_if.busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus_if.src_data = {16'h0000, 16'h6666, 16'h5555, 16'h0000};
    bus_if.req      = 4'b0110;
    @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL simul_winner: gnt=%b want 0010", bus_if.gnt);
    end
    bus_if.req = 4'b0100;
    @(negedge clk);
`ifdef LED_HANDOFF_BLANK_EN
    for (int i = 0; i < 40 && bus_if.gnt === 4'b0000; i++) @(negedge clk);
`endif
    tests_run++;
    if (bus_if.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL simul_next: gnt=%b want 0100", bus_if.gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus_if.src_data = {16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
    bus_if.req      = 4'b0001;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus_if.busy !== 1'b1 || bus_if.signals !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL areset_pre: busy=%b signals=%h want 1/beef", bus_if.busy, bus_if.signals);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.signals !== 16'h0000 || bus_if.busy !== 1'b0 || bus_if.led !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_mid: gnt=%b signals=%h busy=%b led=%b want 0", bus_if.gnt, bus_if.signals, bus_if.busy, bus_if.led);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL areset_regrant: gnt=%b want 0001", bus_if.gnt);
    end
  endtask

  initial begin
    bus_if.req      = '0;
    bus_if.src_data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
